// File: rtl/alu_ser_pkg.sv
// Shared types and default widths for the ALU result serializer.
package alu_ser_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned BEAT_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/alu_ser_parity.sv
// Even parity over the next beat, registered so it lines up with Out_Data.
module alu_ser_parity
    import alu_ser_pkg::*;
#(
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [BEAT_W-1:0] beat_i,
    output logic              parity_o
);

    logic parity_q;

    // Parity of the beat that will be visible after this edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^beat_i;
        end
    end

    assign parity_o = parity_q;

endmodule

// File: rtl/alu_result_serializer.sv
// Splits one DATA_W ALU result into NUM_BEATS BEAT_W-wide beats, LSB beat first.
// Optional feature macro: ALU_SER_PARITY_EN adds the Out_Parity port (even parity per beat).
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned BEAT_W = BEAT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Result,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [BEAT_W-1:0] Out_Data,
    output logic              Out_Last,
`ifdef ALU_SER_PARITY_EN
    output logic              Out_Parity,
`endif
    output logic              Busy
);

    localparam int unsigned NUM_BEATS = DATA_W / BEAT_W;
    localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    // The result word must split into a whole number of beats.
    if ((DATA_W % BEAT_W) != 0) begin : g_width_check
        $error("alu_result_serializer: DATA_W must be a multiple of BEAT_W");
    end

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;

    assign cnt_inc = count_q + CNT_W'(1);

    // State, shift register, beat counter and output flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Capture in IDLE, shift out one beat per downstream handshake in SEND.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        valid_d    = valid_q;
        last_d     = last_q;
        in_ready_d = in_ready_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (In_Valid && in_ready_q) begin
                    state_d    = SEND;
                    shift_d    = In_Result;
                    count_d    = '0;
                    valid_d    = 1'b1;
                    last_d     = (NUM_BEATS == 1);
                    in_ready_d = 1'b0;
                end
            end
            SEND: begin
                if (valid_q && Out_Ready) begin
                    shift_d = shift_q >> BEAT_W;
                    if (last_q) begin
                        state_d    = IDLE;
                        count_d    = '0;
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        in_ready_d = 1'b1;
                    end else begin
                        count_d = cnt_inc;
                        last_d  = (cnt_inc == LAST_CNT);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign In_Ready  = in_ready_q;
    assign Out_Valid = valid_q;
    assign Out_Data  = shift_q[BEAT_W-1:0];
    assign Out_Last  = last_q;
    assign Busy      = (state_q == SEND);

`ifdef ALU_SER_PARITY_EN
    // Parity tracks the next beat so it stays aligned with Out_Data, including stalls.
    alu_ser_parity #(
        .BEAT_W (BEAT_W)
    ) u_parity (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .beat_i   (shift_d[BEAT_W-1:0]),
        .parity_o (Out_Parity)
    );
`endif

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer (table vectors, corner sequences, random vs queue model).
module tb_alu_result_serializer;

    logic         Clk;
    logic         Reset_n;
    logic         In_Valid;
    logic         In_Ready;
    logic [127:0] In_Result;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [31:0]  Out_Data;
    logic         Out_Last;
    logic         Busy;
`ifdef ALU_SER_PARITY_EN
    logic         Out_Parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_result_serializer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Result (In_Result),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Out_Last  (Out_Last),
`ifdef ALU_SER_PARITY_EN
        .Out_Parity(Out_Parity),
`endif
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [127:0]      res;
        logic [3:0][31:0]  beats;
    } vec_t;

    vec_t tbl [4];

    function automatic vec_t mk(input logic [127:0] r, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3);
        vec_t v;
        v.res      = r;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Checks one visible beat; the caller decides whether it is accepted.
    task automatic chk_beat(input string name, input logic [31:0] exp_data, input logic exp_last);
        chk({name, "_valid"}, 128'(Out_Valid), 128'(1'b1));
        chk({name, "_data"}, 128'(Out_Data), 128'(exp_data));
        chk({name, "_last"}, 128'(Out_Last), 128'(exp_last));
        chk({name, "_busy"}, 128'(Busy), 128'(1'b1));
`ifdef ALU_SER_PARITY_EN
        chk({name, "_par"}, 128'(Out_Parity), 128'(^exp_data));
`endif
    endtask

    // Hands one result to the DUT, assuming it is idle with In_Ready high.
    task automatic send(input logic [127:0] r);
        chk("send_in_ready", 128'(In_Ready), 128'(1'b1));
        In_Valid  = 1'b1;
        In_Result = r;
        step();
        In_Valid  = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, 128'(Out_Valid), 128'(1'b0));
        chk({name, "_busy"}, 128'(Busy), 128'(1'b0));
        chk({name, "_in_ready"}, 128'(In_Ready), 128'(1'b1));
    endtask

    logic [31:0]  q [$];
    logic [127:0] v1, v2;

    initial begin
        Reset_n   = 1'b0;
        In_Valid  = 1'b0;
        In_Result = '0;
        Out_Ready = 1'b0;

        tbl[0] = mk(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                    32'h7654_3210, 32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567);
        tbl[1] = mk(128'h1, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
        tbl[2] = mk({128{1'b1}}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tbl[3] = mk(128'hDEAD_BEEF_0000_0000_CAFE_F00D_8000_0001,
                    32'h8000_0001, 32'hCAFE_F00D, 32'h0000_0000, 32'hDEAD_BEEF);

        // Reset held for 3 cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", 128'(Out_Valid), 128'(1'b0));
            chk("rst_data", 128'(Out_Data), 128'(0));
            chk("rst_last", 128'(Out_Last), 128'(1'b0));
            chk("rst_busy", 128'(Busy), 128'(1'b0));
            chk("rst_in_ready", 128'(In_Ready), 128'(1'b0));
`ifdef ALU_SER_PARITY_EN
            chk("rst_par", 128'(Out_Parity), 128'(1'b0));
`endif
        end
        Reset_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", 128'(In_Ready), 128'(1'b0));
        step();
        chk("rel_in_ready_post", 128'(In_Ready), 128'(1'b1));

        // Table vectors at full throughput.
        Out_Ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send(tbl[t].res);
            for (int b = 0; b < 4; b++) begin
                chk_beat($sformatf("tbl%0d_b%0d", t, b), tbl[t].beats[b], (b == 3));
                step();
            end
            chk_idle($sformatf("tbl%0d_end", t));
        end

        // Stall on the second beat for 5 cycles.
        send(tbl[0].res);
        chk_beat("stall_b0", 32'h7654_3210, 1'b0);
        step();
        Out_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_beat("stall_hold", 32'hFEDC_BA98, 1'b0);
            step();
        end
        Out_Ready = 1'b1;
        chk_beat("stall_b1", 32'hFEDC_BA98, 1'b0);
        step();
        chk_beat("stall_b2", 32'h89AB_CDEF, 1'b0);
        step();
        chk_beat("stall_b3", 32'h0123_4567, 1'b1);
        step();
        chk_idle("stall_end");

        // In_Valid held high with a new word during SEND must not be captured.
        v1 = 128'hA0A0_A0A3_B1B1_B1B2_C2C2_C2C1_D3D3_D3D0;
        v2 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
        send(v1);
        In_Valid  = 1'b1;
        In_Result = v2;
        chk_beat("ovr_b0", 32'hD3D3_D3D0, 1'b0);
        chk("ovr_in_ready", 128'(In_Ready), 128'(1'b0));
        step();
        chk_beat("ovr_b1", 32'hC2C2_C2C1, 1'b0);
        step();
        chk_beat("ovr_b2", 32'hB1B1_B1B2, 1'b0);
        step();
        chk_beat("ovr_b3", 32'hA0A0_A0A3, 1'b1);
        step();
        chk_idle("ovr_gap");
        step();
        In_Valid = 1'b0;
        chk_beat("ovr2_b0", 32'h4444_4444, 1'b0);
        step();
        chk_beat("ovr2_b1", 32'h3333_3333, 1'b0);
        step();
        chk_beat("ovr2_b2", 32'h2222_2222, 1'b0);
        step();
        chk_beat("ovr2_b3", 32'h1111_1111, 1'b1);
        step();
        chk_idle("ovr2_end");

        // Reset in the middle of a result, then a fresh result starts at beat 0.
        send(tbl[3].res);
        step();
        chk_beat("mid_b1", 32'hCAFE_F00D, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(Out_Valid), 128'(1'b0));
        chk("mid_rst_last", 128'(Out_Last), 128'(1'b0));
        chk("mid_rst_busy", 128'(Busy), 128'(1'b0));
        chk("mid_rst_data", 128'(Out_Data), 128'(0));
        step();
        chk("mid_rst_hold_valid", 128'(Out_Valid), 128'(1'b0));
        Reset_n = 1'b1;
        step();
        chk_idle("mid_rel");
        send(tbl[0].res);
        for (int b = 0; b < 4; b++) begin
            chk_beat($sformatf("mid_new_b%0d", b), tbl[0].beats[b], (b == 3));
            step();
        end
        chk_idle("mid_new_end");

`ifdef ALU_SER_PARITY_EN
        // Single set bit: only beat 0 has odd parity.
        send(128'h1);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("par1_b%0d", b), 128'(Out_Parity), 128'(b == 0));
            step();
        end
`endif

        // Random traffic against a queue of pending beats.
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_valid", 128'(Out_Valid), 128'(q.size() != 0));
            chk("rnd_busy", 128'(Busy), 128'(q.size() != 0));
            chk("rnd_in_ready", 128'(In_Ready), 128'(q.size() == 0));
            if (q.size() != 0) begin
                chk("rnd_data", 128'(Out_Data), 128'(q[0]));
                chk("rnd_last", 128'(Out_Last), 128'(q.size() == 1));
            end
`ifdef ALU_SER_PARITY_EN
            chk("rnd_par", 128'(Out_Parity), 128'((q.size() != 0) ? ^q[0] : 1'b0));
`endif
            In_Valid  = ($urandom_range(0, 3) != 0);
            In_Result = {$urandom, $urandom, $urandom, $urandom};
            Out_Ready = ($urandom_range(0, 3) != 0);
            if (q.size() != 0) begin
                if (Out_Ready) void'(q.pop_front());
            end else if (In_Valid) begin
                for (int b = 0; b < 4; b++) q.push_back(In_Result[b*32 +: 32]);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
